// File: rtl/riscv_memory.sv
// ---------------------------------------------------------------------------
// riscv_memory
//
// Word-addressed memory for the RISC-V core. It has one independent read
// channel and one independent write channel, each with a valid/ack handshake.
// Both channels complete in a single cycle and never apply backpressure. The
// memory serves instruction fetch and load/store traffic.
//
// Addressing: no byte shift is applied (address 3 selects word 3). Only the
// low AW address bits index the array, so out-of-range addresses wrap.
//
// Power-up contents: word 0 = 0x00100133 (add x2,x0,x1), all other words 0.
//
// Parameters:
//   DEPTH      number of 32-bit words (power of two)
//   AW         index width, $clog2(DEPTH)
//   INIT_FILE  hex image path (not consumed by this build)
//
// Ports:
//   clk                in   rising-edge clock
//   reset              in   asynchronous active-low reset. It clears the
//                           outputs only and leaves the array untouched.
//   mem_rd_addr        in   read word address
//   mem_rd_addr_valid  in   read request
//   mem_rd_data        out  registered read data. It holds its value when
//                           no read is in flight.
//   mem_rd_ack         out  read completion, one cycle after the request
//   mem_wr_addr        in   write word address
//   mem_wr_data        in   write data
//   mem_wr_data_valid  in   write request
//   mem_wr_ack         out  write completion, one cycle after the request
// ---------------------------------------------------------------------------
module riscv_memory #(
    parameter int DEPTH     = 256,
    parameter int AW        = $clog2(DEPTH),
    parameter     INIT_FILE = "mem_init.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_rd_addr,
    input  logic        mem_rd_addr_valid,
    output logic [31:0] mem_rd_data,
    output logic        mem_rd_ack,
    input  logic [31:0] mem_wr_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr_data_valid,
    output logic        mem_wr_ack
);

    localparam logic [31:0] BOOT_WORD = 32'h0010_0133;

    // Storage array
    logic [31:0] mem_q [DEPTH] = '{0: BOOT_WORD, default: 32'h0};

    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          wr_en;

    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_ack_q,  rd_ack_d;
    logic          wr_ack_q,  wr_ack_d;

    // The upper address bits wrap away by design. INIT_FILE is not consumed.
    logic unused_bits;
    assign unused_bits = ^{mem_rd_addr[31:AW], mem_wr_addr[31:AW], INIT_FILE};

    assign rd_idx = mem_rd_addr[AW-1:0];
    assign wr_idx = mem_wr_addr[AW-1:0];

    // Reset is part of the write enable, so an edge seen while reset is low
    // cannot corrupt the array.
    assign wr_en  = mem_wr_data_valid & reset;

    // Next-state for the read and ack registers. The read value comes from
    // mem_q before this edge's write lands. As a result, a same-index read and
    // write return the old word (read-first).
    always_comb begin
        rd_data_d = rd_data_q;
        rd_ack_d  = mem_rd_addr_valid;
        wr_ack_d  = mem_wr_data_valid;
        if (mem_rd_addr_valid) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= 32'h0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_ack_d;
            wr_ack_q  <= wr_ack_d;
        end
    end

    // Array write port. There is no reset term because contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= mem_wr_data;
        end
    end

    assign mem_rd_data = rd_data_q;
    assign mem_rd_ack  = rd_ack_q;
    assign mem_wr_ack  = wr_ack_q;

endmodule

// File: tb/tb_riscv_memory.sv
// ---------------------------------------------------------------------------
// Testbench for riscv_memory. A behavioural model of the word array tracks
// every accepted request. A compare process checks all outputs on every
// falling edge. Directed steps pin the model with literal values, and a
// randomized phase then exercises wrap-around and same-index collisions.
// ---------------------------------------------------------------------------
module tb_riscv_memory;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ack;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] model [DEPTH];
    logic [31:0] exp_rd_data;
    logic        exp_rd_ack;
    logic        exp_wr_ack;

    riscv_memory #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_rd_addr       (rd_addr),
        .mem_rd_addr_valid (rd_valid),
        .mem_rd_data       (rd_data),
        .mem_rd_ack        (rd_ack),
        .mem_wr_addr       (wr_addr),
        .mem_wr_data       (wr_data),
        .mem_wr_data_valid (wr_valid),
        .mem_wr_ack        (wr_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model. The read sees the array before this edge's write.
    // A reset edge clears the outputs and never changes the array.
    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        model[0]    = 32'h0010_0133;
        exp_rd_data = 32'h0;
        exp_rd_ack  = 1'b0;
        exp_wr_ack  = 1'b0;
    end

    always @(posedge clk) begin
        if (reset !== 1'b1) begin
            exp_rd_data = 32'h0;
            exp_rd_ack  = 1'b0;
            exp_wr_ack  = 1'b0;
        end else begin
            exp_rd_ack = rd_valid;
            exp_wr_ack = wr_valid;
            if (rd_valid) exp_rd_data = model[rd_addr % DEPTH];
            if (wr_valid) model[wr_addr % DEPTH] = wr_data;
        end
    end

    always @(negedge reset) begin
        exp_rd_data = 32'h0;
        exp_rd_ack  = 1'b0;
        exp_wr_ack  = 1'b0;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("rd_ack",  {31'h0, rd_ack}, {31'h0, exp_rd_ack});
        chk("wr_ack",  {31'h0, wr_ack}, {31'h0, exp_wr_ack});
        chk("rd_data", rd_data, exp_rd_data);
    end

    task automatic drive(input logic rv, input logic [31:0] ra,
                         input logic wv, input logic [31:0] wa, input logic [31:0] wd);
        rd_valid = rv;
        rd_addr  = ra;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 32'd0, 1'b1, 32'd9, 32'hDEAD_BEEF);

        // Reset held low with both requests active
        repeat (2) begin
            @(negedge clk);
            chk("reset_rd_ack", {31'h0, rd_ack}, 32'h0);
            chk("reset_wr_ack", {31'h0, wr_ack}, 32'h0);
            chk("reset_rd_data", rd_data, 32'h0);
        end

        // Boot word read
        reset = 1'b1;
        drive(1'b1, 32'd0, 1'b0, 32'd0, 32'h0);
        @(negedge clk);
        chk("boot_ack", {31'h0, rd_ack}, 32'h1);
        chk("boot_word", rd_data, 32'h0010_0133);

        // Idle read: ack drops, data holds
        drive(1'b0, 32'd1, 1'b0, 32'd0, 32'h0);
        @(negedge clk);
        chk("idle_ack", {31'h0, rd_ack}, 32'h0);
        chk("idle_hold", rd_data, 32'h0010_0133);

        // Write then read word 3
        drive(1'b0, 32'd0, 1'b1, 32'd3, 32'h2F);
        @(negedge clk);
        chk("wr3_ack", {31'h0, wr_ack}, 32'h1);
        drive(1'b1, 32'd3, 1'b0, 32'd0, 32'h0);
        @(negedge clk);
        chk("rd3_wr_ack", {31'h0, wr_ack}, 32'h0);
        chk("rd3_ack", {31'h0, rd_ack}, 32'h1);
        chk("rd3_data", rd_data, 32'h2F);

        // Same-index read and write: read-first
        drive(1'b1, 32'd5, 1'b1, 32'd5, 32'hA5);
        @(negedge clk);
        chk("coll_old", rd_data, 32'h0);
        drive(1'b1, 32'd5, 1'b0, 32'd0, 32'h0);
        @(negedge clk);
        chk("coll_new", rd_data, 32'hA5);

        // Address wrap
        drive(1'b0, 32'd0, 1'b1, DEPTH + 7, 32'h1234);
        @(negedge clk);
        drive(1'b1, 32'd7, 1'b0, 32'd0, 32'h0);
        @(negedge clk);
        chk("wrap_data", rd_data, 32'h1234);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, wa;
            ra = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
            wa = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) wa = ra;
            drive($urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0, wa, $urandom);
            @(negedge clk);
        end

        // Mid-stream asynchronous reset with both acks high
        drive(1'b1, 32'd3, 1'b1, 32'd12, 32'h5555_AAAA);
        @(negedge clk);
        chk("pre_rst_rd_ack", {31'h0, rd_ack}, 32'h1);
        chk("pre_rst_wr_ack", {31'h0, wr_ack}, 32'h1);
        drive(1'b1, 32'd3, 1'b1, 32'd12, 32'h7777_0000);
        #2 reset = 1'b0;
        #1;
        chk("async_rd_ack", {31'h0, rd_ack}, 32'h0);
        chk("async_wr_ack", {31'h0, wr_ack}, 32'h0);
        chk("async_rd_data", rd_data, 32'h0);

        // The write request stays active through the reset cycle and must be
        // ignored, so word 12 keeps its earlier value.
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 32'd12, 1'b0, 32'd0, 32'h0);
        @(negedge clk);
        chk("post_rst_word12", rd_data, 32'h5555_AAAA);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 32'h0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
